uart_tx_arb: RTL

Round-robin arbiter and sequencer that shares one UART transmitter and its baud generator among up to four byte requesters. Each requester supplies a byte and a 2-bit baud select (00=2400, 01=4800, 10=9600, 11=19200). The block grants one request at a time and reprograms the baud generator when the rate changes, waiting for it to realign. It then launches the transmitter, tracks the frame to completion, and enforces an inter-frame guard gap before the next grant. It sits between the requester-side logic and the baud generator and transmitter pair.

---
 rtl/uart_tx_arb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter and sequencer sharing one UART transmitter
// and its baud generator among up to four byte requesters.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   req_valid  per-requester request pending
//   req_data   requester i byte at [8i+7:8i]
//   req_baud   requester i baud select at [2i+1:2i] (00=2400 .. 11=19200)
//   req_ready  one-cycle one-hot accept pulse
//   baud_rate  select driven to the baud generator
//   baud_tick  16x oversample tick from the baud generator
//   tx_start   one-cycle launch pulse to the transmitter
//   tx_data    byte to transmit, stable from tx_start to frame end
//   tx_busy    transmitter frame in progress
//   grant_id   index of the current or most recent grant
//   busy       high whenever the sequencer is not idle
module uart_tx_arb #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GUARD_TICKS  = 16,
    parameter int unsigned SETTLE_TICKS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [2*NUM_REQ-1:0]   req_baud,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [1:0]             baud_rate,
    input  logic                   baud_tick,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [1:0]             grant_id,
    output logic                   busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETTLE    = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] GUARD     = 3'd5;

    localparam int         NREQ        = int'(NUM_REQ);
    localparam logic [1:0] LAST_RST    = 2'(NUM_REQ - 1);
    // Terminal counts: the exit fires on the tick that would make the count reach N.
    localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_TICKS - 1);
    localparam logic [4:0] GUARD_LAST  = 5'(GUARD_TICKS - 1);

    logic [2:0]         state_q, state_d;
    logic [1:0]         last_q, last_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;
    logic [1:0]         baud_q, baud_d;
    logic [1:0]         grant_q, grant_d;
    logic               busy_q, busy_d;

    // Arbitration result
    logic               found;
    logic [1:0]         win;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]         sel_data;
    logic [1:0]         sel_baud;
    int                 tgt;

    // Round-robin search starting just after the previous grant.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        win_onehot = '0;
        sel_data   = '0;
        sel_baud   = '0;
        tgt        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            tgt = (int'(last_q) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (i == tgt) && req_valid[i]) begin
                    found = 1'b1;
                    win   = 2'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (2'(i) == win) begin
                win_onehot[i] = found;
                sel_data      = req_data[8*i +: 8];
                sel_baud      = req_baud[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ready_d = '0;
        start_d = 1'b0;
        data_d  = data_q;
        baud_d  = baud_q;
        grant_d = grant_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    last_d  = win;
                    grant_d = win;
                    data_d  = sel_data;
                    ready_d = win_onehot;
                    if (sel_baud != baud_q) begin
                        baud_d  = sel_baud;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        state_d = START;
                    end
                end
            end
            // The first tick after a rate change may have a stale period, so
            // wait for SETTLE_TICKS of them before launching.
            SETTLE: begin
                if (baud_tick) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            START: begin
                start_d = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GUARD_TICKS != 0) begin
                        cnt_d   = '0;
                        state_d = GUARD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GUARD: begin
                if (baud_tick) begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            ready_q <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            baud_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            start_q <= start_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign baud_rate = baud_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;

endmodule
